alu_cmd_driver: RTL and testbench
=================================

# alu_cmd_driver

Command-side initiator for the parameterized unsigned ALU. It accepts operation requests over a valid/ready command channel and drives the ALU's opcode/operand/set interface. It captures the registered result and overflow/underflow flags one cycle later and returns them over a valid/ready response channel. It keeps an internal accumulator for chained operations, plus sticky overflow/underflow flags.

## Interface
- WIDTH, 4, datapath width; must match the attached ALU; minimum 2.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset; also wired to the ALU's reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_opcode  in  4  ALU opcode:
  - 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 ZERO, 5 AND, 6 OR, 7 XOR, 8 INV, 9 NOR, 10 SL, 11 SR, 12 RL, 13 RR.
  - 14 and 15 are illegal.
- cmd_a  in  WIDTH  operand A, used when cmd_acc_sel=0.
- cmd_b  in  WIDTH  operand B.
- cmd_acc_sel  in  1  1: operand A is the accumulator instead of cmd_a.
- cmd_wb  in  1  1: write the result into the accumulator.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH  ALU result.
- rsp_overflow  out  1  ALU overflow flag for this op.
- rsp_underflow  out  1  ALU underflow flag for this op.
- rsp_err  out  1  illegal opcode; the ALU was not exercised.
- acc  out  WIDTH  current accumulator value.
- sticky_ovf  out  1  OR of all reported overflows since reset/clear.
- sticky_unf  out  1  OR of all reported underflows since reset/clear.
- sticky_clr  in  1  clears both sticky flags.
- alu_opcode  out  4  to ALU opcode.
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_set  out  1  to ALU set; single-cycle pulse.
- alu_out  in  WIDTH  from ALU out.
- alu_overflow  in  1  from ALU overflow.
- alu_underflow  in  1  from ALU underflow.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESPOND.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch opcode, the effective A (acc if cmd_acc_sel, else cmd_a), B, and wb.
  - Legal opcode -> ISSUE.
  - Opcode 14/15 -> RESPOND with rsp_err=1, rsp_result=0, both flags 0.
- ISSUE: alu_set=1 for exactly this cycle; go to CAPTURE.
- CAPTURE:
  - Register alu_out/alu_overflow/alu_underflow into the response registers.
  - If wb, acc <= alu_out.
  - sticky_ovf |= alu_overflow; sticky_unf |= alu_underflow.
  - Go to RESPOND.
- RESPOND: rsp_valid=1 with stable fields until rsp_ready; on the handshake go to IDLE.
- cmd_ready=0 in every state except IDLE; at most one command in flight.
- Outside ISSUE, alu_set=0. alu_opcode/alu_a/alu_b hold the last latched values at all times, so the ALU inputs are stable around the set edge.
- Operand A is sampled from acc at acceptance. A chained command therefore sees the previous command's writeback, because writeback completes before IDLE.
- sticky_clr:
  - Takes effect at the next edge in any state.
  - If asserted in the same cycle as a CAPTURE that sets a flag, the new flag wins (the set dominates).
- Illegal opcodes do not affect acc or the sticky flags.
- Arithmetic width and wrap behaviour are entirely the ALU's. The driver passes its results through unmodified: no extension, no saturation.

## Timing
- Reset values:
  - State IDLE, cmd_ready=1.
  - rsp_valid=0, rsp_result=0, rsp_overflow=0, rsp_underflow=0, rsp_err=0.
  - acc=0, sticky_ovf=0, sticky_unf=0.
  - alu_set=0, alu_opcode=0, alu_a=0, alu_b=0.
- Legal op latency:
  - Command accepted at edge E.
  - alu_set high during cycle E..E+1.
  - ALU updates at E+1; driver captures at E+2.
  - rsp_valid is high from E+2, i.e. 2 cycles after acceptance.
- Illegal op: rsp_valid high from E (the cycle immediately after acceptance).
- Throughput: with rsp_ready held high, one legal op per 4 cycles; next cmd_ready at E+3.
- Reset in any state, including mid-ISSUE or CAPTURE:
  - Returns to IDLE, drops rsp_valid, and clears acc and the sticky flags.
  - The in-flight command is discarded with no response.
  - The ALU is reset by the same signal.
- rsp_ready asserted while rsp_valid=0 is ignored.

## Test plan
- WIDTH=4, ADD A=9 B=8 -> rsp_result=1, rsp_overflow=1, rsp_underflow=0, sticky_ovf=1; rsp_valid 2 cycles after acceptance; alu_set high exactly 1 cycle.
- SUB A=3 B=5, cmd_wb=1 -> rsp_result=14, rsp_underflow=1, acc=14, sticky_unf=1; then sticky_clr for 1 cycle -> both sticky flags 0, acc still 14.
- From reset, three INC with cmd_acc_sel=1 and cmd_wb=1 -> results 1, 2, 3, acc=3. Then RL with acc_sel (A=3) -> 6; then RR with A=1 and no wb -> 8, with acc unchanged at 3.
- rsp_ready held low 5 cycles in RESPOND with cmd_valid high -> rsp_valid and the fields stay stable, cmd_ready stays 0, alu_set never pulses; releasing rsp_ready gives cmd_ready=1 the next cycle.
- Opcode 14 -> rsp_err=1 and rsp_result=0 one cycle after acceptance; alu_set never asserted; acc and sticky flags unchanged.
- Reset asserted during CAPTURE of an ADD with wb and overflow -> next cycle IDLE, rsp_valid=0, acc=0, sticky_ovf=0, no response ever produced.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the unsigned ALU: valid/ready command in, one op in flight,
// registered result/flags returned on a valid/ready response channel, plus accumulator and sticky flags.
module alu_cmd_driver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_acc_sel,
    input  logic             cmd_wb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc,
    output logic             sticky_ovf,
    output logic             sticky_unf,
    input  logic             sticky_clr,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_set,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    input  logic             alu_underflow
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    logic [1:0]       r_state;
    logic [3:0]       r_opcode;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_wb;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic             r_unf;
    logic             r_err;
    logic [WIDTH-1:0] r_acc;
    logic             r_sticky_ovf;
    logic             r_sticky_unf;

    logic             w_illegal;
    logic             w_capture;

    assign w_illegal = (cmd_opcode[3:1] == 3'b111);
    assign w_capture = (r_state == S_CAPTURE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_wb     <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_err    <= 1'b0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // A is sampled from the accumulator here, after any prior writeback
                        r_opcode <= cmd_opcode;
                        r_a      <= cmd_acc_sel ? r_acc : cmd_a;
                        r_b      <= cmd_b;
                        r_wb     <= cmd_wb;
                        if (w_illegal) begin
                            r_result <= '0;
                            r_ovf    <= 1'b0;
                            r_unf    <= 1'b0;
                            r_err    <= 1'b1;
                            r_state  <= S_RESPOND;
                        end else begin
                            r_err    <= 1'b0;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_result <= alu_out;
                    r_ovf    <= alu_overflow;
                    r_unf    <= alu_underflow;
                    if (r_wb) begin
                        r_acc <= alu_out;
                    end
                    r_state  <= S_RESPOND;
                end
                default: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // A capture that raises a flag dominates a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky_ovf <= 1'b0;
            r_sticky_unf <= 1'b0;
        end else begin
            r_sticky_ovf <= (r_sticky_ovf & ~sticky_clr) | (w_capture & alu_overflow);
            r_sticky_unf <= (r_sticky_unf & ~sticky_clr) | (w_capture & alu_underflow);
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);
    assign rsp_valid     = (r_state == S_RESPOND);
    assign rsp_result    = r_result;
    assign rsp_overflow  = r_ovf;
    assign rsp_underflow = r_unf;
    assign rsp_err       = r_err;
    assign acc           = r_acc;
    assign sticky_ovf    = r_sticky_ovf;
    assign sticky_unf    = r_sticky_unf;
    assign alu_opcode    = r_opcode;
    assign alu_a         = r_a;
    assign alu_b         = r_b;
    assign alu_set       = (r_state == S_ISSUE);

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: behavioural ALU attached to the driver, directed and random
// commands checked against an arithmetic reference of the accumulator and sticky flags.
module tb_alu_cmd_driver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_opcode;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_acc_sel;
    logic         cmd_wb;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_overflow;
    logic         rsp_underflow;
    logic         rsp_err;
    logic [W-1:0] acc;
    logic         sticky_ovf;
    logic         sticky_unf;
    logic         sticky_clr;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_set;
    logic [W-1:0] alu_out;
    logic         alu_overflow;
    logic         alu_underflow;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [W-1:0] m_acc;
    logic         m_so;
    logic         m_su;

    always #5 clk = ~clk;

    alu_cmd_driver #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc_sel(cmd_acc_sel), .cmd_wb(cmd_wb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow), .rsp_err(rsp_err),
        .acc(acc), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .sticky_clr(sticky_clr),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_set(alu_set),
        .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_underflow(alu_underflow)
    );

    // Unsigned ALU semantics in plain integer arithmetic: returns {ovf, unf, result}
    function automatic logic [W+1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int unsigned ia = a;
        int unsigned ib = b;
        int unsigned m  = 1 << W;
        int unsigned r  = 0;
        logic o = 1'b0;
        logic u = 1'b0;
        case (op)
            4'd0:  begin r = (ia + ib) % m; o = (ia + ib) >= m; end
            4'd1:  begin r = (ia + m - ib) % m; u = ia < ib; end
            4'd2:  begin r = (ia + 1) % m; o = (ia == m - 1); end
            4'd3:  begin r = (ia + m - 1) % m; u = (ia == 0); end
            4'd4:  r = 0;
            4'd5:  r = ia & ib;
            4'd6:  r = ia | ib;
            4'd7:  r = ia ^ ib;
            4'd8:  r = m - 1 - ia;
            4'd9:  r = m - 1 - (ia | ib);
            4'd10: begin r = (ia * 2) % m; o = ia >= m / 2; end
            4'd11: r = ia / 2;
            4'd12: r = (ia * 2) % m + ia / (m / 2);
            4'd13: r = ia / 2 + (ia % 2) * (m / 2);
            default: r = 0;
        endcase
        return {o, u, r[W-1:0]};
    endfunction

    // Registered ALU: updates on the edge where set is sampled high
    always @(posedge clk) begin
        logic [W+1:0] v;
        if (reset) begin
            alu_out <= '0; alu_overflow <= 1'b0; alu_underflow <= 1'b0;
        end else if (alu_set) begin
            v = alu_ref(alu_opcode, alu_a, alu_b);
            alu_out <= v[W-1:0]; alu_overflow <= v[W+1]; alu_underflow <= v[W];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_acc = '0; m_so = 1'b0; m_su = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic accsel, input logic wb, input int hold, input logic clr_cap);
        logic [W+1:0] e;
        logic [W-1:0] eff;
        logic         legal;
        int           lat;
        int           sets;
        legal = (op < 4'd14);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_acc_sel = accsel; cmd_wb = wb;
        check("ready_idle", cmd_ready, 1);
        eff = accsel ? m_acc : a;
        e   = alu_ref(op, eff, b);
        @(posedge clk);
        lat = -1; sets = 0;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) sticky_clr = clr_cap & legal;
            if (k == 2) sticky_clr = 1'b0;
            if (alu_set) begin
                sets++;
                check("alu_opcode", alu_opcode, op);
                check("alu_a", alu_a, eff);
                check("alu_b", alu_b, b);
            end
            if (rsp_valid) lat = k;
            else check("ready_busy", cmd_ready, 0);
        end
        sticky_clr = 1'b0;
        check("latency", lat, legal ? 2 : 0);
        check("set_pulses", sets, legal ? 1 : 0);
        if (legal) begin
            if (clr_cap) begin m_so = 1'b0; m_su = 1'b0; end
            m_so = m_so | e[W+1];
            m_su = m_su | e[W];
            if (wb) m_acc = e[W-1:0];
        end
        check("result", rsp_result, legal ? e[W-1:0] : 0);
        check("rsp_ovf", rsp_overflow, legal ? e[W+1] : 0);
        check("rsp_unf", rsp_underflow, legal ? e[W] : 0);
        check("rsp_err", rsp_err, !legal);
        check("acc", acc, m_acc);
        check("sticky_ovf", sticky_ovf, m_so);
        check("sticky_unf", sticky_unf, m_su);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, legal ? e[W-1:0] : 0);
            check("hold_ready", cmd_ready, 0);
            check("hold_set", alu_set, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("post_valid", rsp_valid, 0);
        check("post_ready", cmd_ready, 1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        m_so = 1'b0; m_su = 1'b0;
        check("clr_ovf", sticky_ovf, 0);
        check("clr_unf", sticky_unf, 0);
        check("clr_acc", acc, m_acc);
    endtask

    task automatic reset_in_capture();
        int seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_a = 4'd9; cmd_b = 4'd8; cmd_acc_sel = 1'b0; cmd_wb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rc_set", alu_set, 1);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_acc = '0; m_so = 1'b0; m_su = 1'b0;
        check("rc_valid", rsp_valid, 0);
        check("rc_ready", cmd_ready, 1);
        check("rc_acc", acc, 0);
        check("rc_sticky_ovf", sticky_ovf, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rc_no_rsp", seen, 0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
        cmd_acc_sel = 1'b0; cmd_wb = 1'b0; rsp_ready = 1'b0; sticky_clr = 1'b0;
        do_reset();
        check("rst_ready", cmd_ready, 1);
        check("rst_valid", rsp_valid, 0);
        check("rst_outs", {rsp_result, rsp_overflow, rsp_underflow, rsp_err}, 0);
        check("rst_acc", {acc, sticky_ovf, sticky_unf}, 0);
        check("rst_alu", {alu_set, alu_opcode, alu_a, alu_b}, 0);

        // stray rsp_ready while idle is ignored
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
        check("stray_ready", {cmd_ready, rsp_valid}, 2'b10);

        run_cmd(4'd0, 4'd9, 4'd8, 1'b0, 1'b0, 0, 1'b0);
        run_cmd(4'd1, 4'd3, 4'd5, 1'b0, 1'b1, 0, 1'b0);
        check("sub_acc", acc, 14);
        pulse_clr();

        do_reset();
        repeat (3) run_cmd(4'd2, 4'd0, 4'd0, 1'b1, 1'b1, 0, 1'b0);
        check("inc_acc", acc, 3);
        run_cmd(4'd12, 4'd0, 4'd0, 1'b1, 1'b0, 0, 1'b0);
        run_cmd(4'd13, 4'd1, 4'd0, 1'b0, 1'b0, 0, 1'b0);
        check("rr_acc", acc, 3);

        run_cmd(4'd0, 4'd7, 4'd2, 1'b0, 1'b0, 5, 1'b0);
        run_cmd(4'd14, 4'd5, 4'd6, 1'b0, 1'b1, 2, 1'b0);
        run_cmd(4'd15, 4'd1, 4'd1, 1'b1, 1'b1, 0, 1'b0);

        // clear coinciding with a flag-setting capture: set wins
        run_cmd(4'd1, 4'd0, 4'd1, 1'b0, 1'b0, 0, 1'b0);
        run_cmd(4'd0, 4'd15, 4'd15, 1'b0, 1'b0, 0, 1'b1);
        check("clr_cap_ovf", sticky_ovf, 1);
        check("clr_cap_unf", sticky_unf, 0);

        reset_in_capture();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) pulse_clr();
            run_cmd(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
